bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that turns the true dual-port BRAM (`dualport`, 16-bit x 1024) into a streaming buffer.
- Upstream producers push words through a valid/ready slave interface.
- The controller writes them through BRAM port A and prefetches them through BRAM port B.
- It presents them on a valid/ready master interface with full throughput: 1 word/cycle in and out simultaneously.

Parameters:
- DW, 16, data width; must equal the BRAM data width.
- AW, 10, BRAM address width; RAM depth = 2**AW words.

Ports:
- clk  in  1  single clock; every flop is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  producer has a word.
- s_ready  out  1  controller accepts a word this cycle.
- s_data  in  DW  producer word.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer takes the head word.
- m_data  out  DW  head word.
- level  out  AW+2  total words held: RAM + in-flight read + output stage.
- ram_wrena  out  1  BRAM port A write enable.
- ram_addra  out  AW  BRAM port A address.
- ram_dina  out  DW  BRAM port A write data.
- ram_rdena  out  1  tied 0.
- ram_wrenb  out  1  tied 0.
- ram_dinb  out  DW  tied 0.
- ram_rdenb  out  1  BRAM port B read enable.
- ram_addrb  out  AW  BRAM port B address.
- ram_doutb  in  DW  BRAM port B read data; valid the cycle after the edge that sampled ram_rdenb=1 (1-cycle latency).

Behaviour:
- Reset (rst=1 at an edge):
  - wptr, rptr, ram_count, inflight and output-stage occupancy go to 0.
  - m_valid=0 and level=0.
  - While rst=1: s_ready=0, ram_wrena=0, ram_rdenb=0.
  - Reset mid-operation discards all held and in-flight words. The RAM is not cleared. A ram_doutb word returning after reset is ignored.
- Accept:
  - s_ready = !rst && (ram_count < 2**AW), computed from registered state only.
  - On s_valid && s_ready, the same cycle drives ram_wrena=1, ram_addra=wptr, ram_dina=s_data.
  - At the edge: wptr increments modulo 2**AW and ram_count increments.
  - ram_wrena=0 otherwise.
- Read issue:
  - pop = m_valid && m_ready.
  - ram_rdenb=1, ram_addrb=rptr when ram_count>0 && (occ + inflight - pop) < 2.
  - At the edge: rptr increments modulo 2**AW, ram_count decrements and inflight is set to 1. inflight is cleared the following edge.
- Simultaneous write and read issue in one cycle leave ram_count unchanged.
- Address collision cannot occur: a write requires ram_count<2**AW and a read requires ram_count>0, so wptr==rptr never coincides with both enables. This is an asserted invariant.
- Output stage is a 2-entry skid buffer with states EMPTY, ONE, TWO:
  - A capture occurs at the edge when inflight=1; the data is ram_doutb.
  - EMPTY -> ONE on capture.
  - ONE -> TWO on capture && !pop.
  - ONE -> EMPTY on pop && !capture.
  - ONE -> ONE on capture && pop; the new word replaces the head.
  - TWO -> ONE on pop; the second entry shifts to head. A capture in TWO is impossible by the issue rule; this is asserted.
- Output:
  - m_valid = (state != EMPTY), registered.
  - m_data = head entry.
  - m_data is stable while m_valid && !m_ready.
- Latency: a word accepted at edge N into an empty FIFO is issued in cycle N+1, captured at edge N+2, and m_valid=1 after edge N+2.
- Throughput: with s_valid=m_ready=1 continuously, after fill there is 1 word/cycle out with no bubbles.
- Capacity: 2**AW + 2 words. Order is strictly FIFO.
- level = ram_count + inflight + occ, updated every edge; its maximum is 2**AW+2.
- Words are unsigned and opaque; there is no arithmetic on data.

Decomposition:
- Package bram_fifo_pkg holds:
  - constants DW=16 and AW=10, matching the dualport geometry;
  - localparam DEPTH = 2**AW;
  - an enum for the output-stage states EMPTY/ONE/TWO.
- One sub-module: fifo_out_skid, the 2-entry output buffer. Its interfaces:
  - capture, cap_data and pop in;
  - m_valid, m_data and occ out.
  - The top keeps the pointers, ram_count, inflight and the issue logic.

Test Plan:
- Reset then single word (AW=3):
  - Push 16'h00FF at edge N with m_ready=1 -> ram_wrena=1/ram_addra=0 in that cycle, ram_rdenb=1/ram_addrb=0 in cycle N+1, m_valid=1 with m_data=16'h00FF after edge N+2, level 1 -> 0 after the pop.
- Fill to full (AW=3, m_ready=0):
  - Push 16'h0001..16'h000A -> all 10 accepted, s_ready=0 after the 10th, level=10, m_data=16'h0001 held stable.
  - An 11th s_valid is not accepted and ram_wrena stays 0.
- Drain order:
  - After the full test, raise m_ready -> 16'h0001..16'h000A appear on consecutive cycles, then m_valid=0, level=0, s_ready=1.
- Streaming with wrap (AW=3):
  - Continuous s_valid/m_ready with 20 words 16'h00A0+i -> output is an in-order identical sequence with no bubbles after the first m_valid; pointers wrap at 8.
  - No cycle has ram_wrena && ram_rdenb && ram_addra==ram_addrb.
- Backpressure toggle:
  - m_ready alternating 1/0 while streaming 16'h00CD, 16'h00AA, ... -> no loss or duplication, and m_data is unchanged during every m_ready=0 cycle.
- Reset mid-operation:
  - Assert rst for 1 cycle with level=5 and inflight=1 -> next cycle m_valid=0, level=0, s_ready=1.
  - The stale ram_doutb is not captured.
  - A subsequent push of 16'h0066 is the next output.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared geometry and output-stage state encoding for the BRAM-backed FIFO.
package bram_fifo_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output skid buffer: absorbs the one-cycle BRAM read latency so
// the master interface can stream a word every cycle.
module fifo_out_skid
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DW = bram_fifo_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [DW-1:0] cap_data,
    input  logic          pop,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    skid_state_t   state;
    logic [DW-1:0] head;
    logic [DW-1:0] second;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            m_valid <= 1'b0;
            occ     <= 2'd0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (capture) begin
                        head    <= cap_data;
                        state   <= ST_ONE;
                        m_valid <= 1'b1;
                        occ     <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (capture && pop) begin
                        head <= cap_data;
                    end else if (capture) begin
                        second <= cap_data;
                        state  <= ST_TWO;
                        occ    <= 2'd2;
                    end else if (pop) begin
                        state   <= ST_EMPTY;
                        m_valid <= 1'b0;
                        occ     <= 2'd0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head  <= second;
                        state <= ST_ONE;
                        occ   <= 2'd1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    m_valid <= 1'b0;
                    occ     <= 2'd0;
                end
            endcase
        end
    end

    assign m_data = head;

    // The issue rule never lets a read land while both entries are occupied.
    a_no_capture_in_two: assert property (@(posedge clk) disable iff (rst)
        !(capture && state == ST_TWO));

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO over a true dual-port BRAM: port A writes, port B prefetches
// into a 2-entry skid buffer for full-rate valid/ready output.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DW = bram_fifo_pkg::DW,
    parameter int unsigned AW = bram_fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW+1:0] level,
    output logic          ram_wrena,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic          ram_rdena,
    output logic          ram_wrenb,
    output logic [DW-1:0] ram_dinb,
    output logic          ram_rdenb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb
);

    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_count;
    logic          inflight;
    logic [1:0]    occ;
    logic          push;
    logic          pop;
    logic          issue;

    // ram_count never exceeds the depth, so "!= full" is "< depth".
    assign s_ready = !rst && (ram_count != FULL_COUNT);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    // occ + inflight - pop < 2, rearranged to avoid a negative intermediate.
    assign issue   = !rst && (ram_count != '0)
                     && (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign ram_wrena = push;
    assign ram_addra = wptr;
    assign ram_dina  = s_data;
    assign ram_rdena = 1'b0;
    assign ram_wrenb = 1'b0;
    assign ram_dinb  = '0;
    assign ram_rdenb = issue;
    assign ram_addrb = rptr;

    assign level = {1'b0, ram_count} + {{(AW+1){1'b0}}, inflight} + {{AW{1'b0}}, occ};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (issue) rptr <= rptr + 1'b1;
            unique case ({push, issue})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
            inflight <= issue;
        end
    end

    fifo_out_skid #(
        .DW(DW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .capture  (inflight),
        .cap_data (ram_doutb),
        .pop      (pop),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .occ      (occ)
    );

    a_no_collision: assert property (@(posedge clk) disable iff (rst)
        !(ram_wrena && ram_rdenb && (ram_addra == ram_addrb)));

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl (AW=3) against a word-queue model
// and a behavioural dual-port RAM.
module tb_bram_fifo_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] level;
    logic          ram_wrena;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          ram_rdena;
    logic          ram_wrenb;
    logic [DW-1:0] ram_dinb;
    logic          ram_rdenb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .ram_wrena (ram_wrena),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_rdena (ram_rdena),
        .ram_wrenb (ram_wrenb),
        .ram_dinb  (ram_dinb),
        .ram_rdenb (ram_rdenb),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural BRAM with 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wrena) mem[ram_addra] <= ram_dina;
        if (ram_rdenb) ram_doutb <= mem[ram_addrb];
    end

    // Reference model: words accepted and not yet popped, in order.
    logic [DW-1:0] q[$];
    int unsigned   wr_idx;
    int unsigned   rd_idx;
    int            vectors;
    int            miscompares;

    logic          smp_sready, smp_wrena, smp_rdenb, smp_mvalid, has_head, acc, popd;
    logic [AW-1:0] smp_addra, smp_addrb, exp_waddr, exp_raddr;
    logic [DW-1:0] smp_mdata, exp_head;

    task automatic drive(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
        @(negedge clk);
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        smp_sready = s_ready;
        smp_wrena  = ram_wrena;
        smp_addra  = ram_addra;
        smp_rdenb  = ram_rdenb;
        smp_addrb  = ram_addrb;
        smp_mvalid = m_valid;
        smp_mdata  = m_data;
        has_head   = (q.size() != 0);
        exp_head   = has_head ? q[0] : '0;
        exp_waddr  = wr_idx[AW-1:0];
        exp_raddr  = rd_idx[AW-1:0];
        acc        = s_valid && s_ready;
        popd       = m_valid && m_ready;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            wr_idx = 0;
            rd_idx = 0;
        end else begin
            if (popd && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(sd);
                wr_idx++;
            end
            if (smp_rdenb) rd_idx++;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 16'h1234, 1'b0);
        vectors++; if (smp_sready !== 1'b0) begin miscompares++; $display("FAIL rst_sready: got %b want 0", smp_sready); end
        vectors++; if (smp_wrena !== 1'b0) begin miscompares++; $display("FAIL rst_wrena: got %b want 0", smp_wrena); end
        vectors++; if (smp_rdenb !== 1'b0) begin miscompares++; $display("FAIL rst_rdenb: got %b want 0", smp_rdenb); end
        vectors++; if ({ram_rdena, ram_wrenb, ram_dinb} !== '0) begin miscompares++;
            $display("FAIL rst_tied: got %b/%b/%h want 0/0/0000", ram_rdena, ram_wrenb, ram_dinb); end
        drive(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mvalid: got %b want 0", m_valid); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", level); end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++; if (smp_sready !== 1'b1) begin miscompares++; $display("FAIL rst_release_sready: got %b want 1", smp_sready); end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b1, 16'h00FF, 1'b1);
        vectors++; if (smp_wrena !== 1'b1 || smp_addra !== 3'd0) begin miscompares++;
            $display("FAIL single_write: got wrena=%b addra=%0d want 1/0", smp_wrena, smp_addra); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL single_level_n: got %0d want 1", level); end
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (smp_rdenb !== 1'b1 || smp_addrb !== 3'd0) begin miscompares++;
            $display("FAIL single_issue: got rdenb=%b addrb=%0d want 1/0", smp_rdenb, smp_addrb); end
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (smp_mvalid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", smp_mvalid); end
        vectors++; if (m_valid !== 1'b1 || m_data !== 16'h00FF) begin miscompares++;
            $display("FAIL single_out: got valid=%b data=%h want 1/00ff", m_valid, m_data); end
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (level !== '0 || m_valid !== 1'b0) begin miscompares++;
            $display("FAIL single_pop: got level=%0d valid=%b want 0/0", level, m_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'(i + 1), 1'b0);
            vectors++; if (smp_sready !== 1'b1) begin miscompares++; $display("FAIL fill_accept%0d: got %b want 1", i, smp_sready); end
            if (smp_mvalid) begin
                vectors++; if (smp_mdata !== exp_head) begin miscompares++;
                    $display("FAIL fill_hold%0d: got %h want %h", i, smp_mdata, exp_head); end
            end
        end
        vectors++; if (level !== 5'd10 || s_ready !== 1'b0) begin miscompares++;
            $display("FAIL fill_full: got level=%0d s_ready=%b want 10/0", level, s_ready); end
        drive(1'b0, 1'b1, 16'h000B, 1'b0);
        vectors++; if (smp_wrena !== 1'b0 || smp_sready !== 1'b0) begin miscompares++;
            $display("FAIL fill_reject: got wrena=%b s_ready=%b want 0/0", smp_wrena, smp_sready); end
        vectors++; if (smp_mvalid !== 1'b1 || smp_mdata !== 16'h0001 || level !== 5'd10) begin miscompares++;
            $display("FAIL fill_head: got valid=%b data=%h level=%0d want 1/0001/10", smp_mvalid, smp_mdata, level); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (smp_mvalid !== 1'b1 || smp_mdata !== 16'(i + 1)) begin miscompares++;
                $display("FAIL drain%0d: got valid=%b data=%h want 1/%h", i, smp_mvalid, smp_mdata, 16'(i + 1)); end
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (smp_mvalid !== 1'b0 || level !== '0 || smp_sready !== 1'b1) begin miscompares++;
            $display("FAIL drain_empty: got valid=%b level=%0d s_ready=%b want 0/0/1", smp_mvalid, level, smp_sready); end
    endtask

    task automatic test_stream();
        int  sent = 0;
        int  got = 0;
        int  cycles = 0;
        bit  seen = 0;
        while (got < 20 && cycles < 100) begin
            drive(1'b0, sent < 20, 16'(16'h00A0 + sent), 1'b1);
            if (acc) sent++;
            cycles++;
            vectors++; if (smp_wrena && smp_rdenb && smp_addra == smp_addrb) begin miscompares++;
                $display("FAIL stream_collision: got addr %0d on both ports want distinct", smp_addra); end
            if (smp_wrena) begin
                vectors++; if (smp_addra !== exp_waddr) begin miscompares++;
                    $display("FAIL stream_addra: got %0d want %0d", smp_addra, exp_waddr); end
            end
            if (smp_rdenb) begin
                vectors++; if (smp_addrb !== exp_raddr) begin miscompares++;
                    $display("FAIL stream_addrb: got %0d want %0d", smp_addrb, exp_raddr); end
            end
            if (smp_mvalid) begin
                vectors++; if (smp_mdata !== 16'(16'h00A0 + got)) begin miscompares++;
                    $display("FAIL stream_data%0d: got %h want %h", got, smp_mdata, 16'(16'h00A0 + got)); end
                seen = 1;
                got++;
            end else if (seen) begin
                vectors++; miscompares++;
                $display("FAIL stream_bubble: got m_valid=0 after %0d words want 1", got);
            end
            vectors++; if (level !== 5'(q.size())) begin miscompares++;
                $display("FAIL stream_level: got %0d want %0d", level, q.size()); end
        end
        vectors++; if (got != 20) begin miscompares++; $display("FAIL stream_count: got %0d words want 20", got); end
    endtask

    task automatic test_backpressure();
        logic          prev_hold = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] d;
        logic          sv;
        for (int c = 0; c < 160; c++) begin
            d  = (c == 0) ? 16'h00CD : (c == 1) ? 16'h00AA : 16'($urandom);
            sv = (c < 2) || ($urandom_range(0, 3) != 0);
            drive(1'b0, sv, d, (c % 2) == 0);
            if (smp_mvalid) begin
                vectors++; if (!has_head || smp_mdata !== exp_head) begin miscompares++;
                    $display("FAIL bp_data%0d: got %h want %h", c, smp_mdata, exp_head); end
                if (prev_hold) begin
                    vectors++; if (smp_mdata !== prev_data) begin miscompares++;
                        $display("FAIL bp_stable%0d: got %h want %h", c, smp_mdata, prev_data); end
                end
            end
            prev_hold = smp_mvalid && !m_ready;
            prev_data = smp_mdata;
            vectors++; if (level !== 5'(q.size())) begin miscompares++;
                $display("FAIL bp_level%0d: got %0d want %0d", c, level, q.size()); end
        end
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (smp_mvalid !== 1'b1 || smp_mdata !== exp_head) begin miscompares++;
                $display("FAIL bp_drain%0d: got valid=%b data=%h want 1/%h", c, smp_mvalid, smp_mdata, exp_head); end
        end
        vectors++; if (level !== '0 || m_valid !== 1'b0) begin miscompares++;
            $display("FAIL bp_empty: got level=%0d valid=%b want 0/0", level, m_valid); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'(16'h0050 + i), 1'b0);
        drive(1'b0, 1'b1, 16'h0055, 1'b1);
        vectors++; if (level !== 5'd5 || smp_rdenb !== 1'b1) begin miscompares++;
            $display("FAIL mid_setup: got level=%0d rdenb=%b want 5/1", level, smp_rdenb); end
        drive(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (m_valid !== 1'b0 || level !== '0) begin miscompares++;
            $display("FAIL mid_reset: got valid=%b level=%0d want 0/0", m_valid, level); end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++; if (smp_sready !== 1'b1 || smp_mvalid !== 1'b0) begin miscompares++;
            $display("FAIL mid_after: got s_ready=%b valid=%b want 1/0", smp_sready, smp_mvalid); end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++; if (smp_mvalid !== 1'b0 || level !== '0) begin miscompares++;
            $display("FAIL mid_stale: got valid=%b level=%0d want 0/0", smp_mvalid, level); end
        drive(1'b0, 1'b1, 16'h0066, 1'b1);
        for (int c = 0; c < 10 && !found; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (smp_mvalid) begin
                found = 1;
                vectors++; if (smp_mdata !== 16'h0066) begin miscompares++;
                    $display("FAIL mid_next: got %h want 0066", smp_mdata); end
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_timeout: got no m_valid want 0066"); end
    endtask

    initial begin
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        wr_idx      = 0;
        rd_idx      = 0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1);
    end

endmodule
